mc_control: RTL and testbench
=============================

// Module: mc_control
// PURPOSE
//   Main control FSM for the multi-cycle datapath. Sequences the PC/next-PC
//   unit, instruction register, register file, ALU and the shared
//   instruction/data memory. The PC updates only on the cycles this block
//   enables; branch and jump selection is driven from here. One shared memory
//   port, with a ready handshake so slow memory stalls the FSM.
// PARAMETERS
//   OPW       6   opcode width, instr[31:26]
//   STW       4   state register width
// PORTS
//   clk           in   1    system clock, all state on posedge
//   rst_n         in   1    synchronous reset, active-low
//   opcode        in   OPW  IR[31:26], valid from DECODE onward
//   zero          in   1    ALU zero flag, sampled in BRANCH
//   mem_ready     in   1    memory completes the current access this cycle
//   mem_read      out  1    memory read request, held until mem_ready
//   mem_write     out  1    memory write request, held until mem_ready
//   iord          out  1    0 = PC addresses memory; 1 = ALUOut addresses memory
//   ir_write      out  1    load IR (FETCH and mem_ready only)
//   pc_write      out  1    unconditional PC load
//   pc_write_cond out  1    PC load qualified by zero (beq)
//   pc_source     out  2    00 = pc+1, 01 = branch target, 10 = jump target
//   alu_src_a     out  1    0 = PC, 1 = rs
//   alu_src_b     out  2    00 = rt, 01 = const 1, 10 = sext imm, 11 = imm<<2
//   alu_op        out  2    00 = add, 01 = sub, 10 = funct-decoded
//   reg_dst       out  1    0 = rt, 1 = rd
//   mem_to_reg    out  1    0 = ALUOut, 1 = MDR
//   reg_write     out  1    register file write enable
//   illegal_op    out  1    1-cycle pulse on an undefined opcode in DECODE
//   state_o       out  STW  current state, debug visibility
// BEHAVIOUR
//   - Moore FSM. Outputs decode from the state register only, except that
//     ir_write and pc_write in FETCH are ANDed with mem_ready.
//   - While rst_n = 0 at a clock edge: state <= FETCH. All outputs read 0 in
//     any cycle where rst_n = 0. Reset mid-instruction aborts it; no partial
//     register or memory write is issued after that edge.
//   - FETCH(0): mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01,
//     pc_source = 00. Stays in FETCH while mem_ready = 0. On mem_ready:
//     ir_write = 1, pc_write = 1, next state DECODE.
//   - DECODE(1): alu_src_b = 11, precomputes the branch target. Next state by
//     opcode: 00 -> EXEC, 23 -> MEMADR, 2B -> MEMADR, 04 -> BRANCH,
//     02 -> JUMP. Any other opcode: illegal_op = 1, next state FETCH, no
//     architectural side effect.
//   - MEMADR(2): src_a = 1, src_b = 10, alu_op = 00. lw -> MEMRD; sw -> MEMWR.
//   - MEMRD(3): mem_read = 1, iord = 1. Waits on mem_ready, then -> MEMWB.
//   - MEMWB(4): reg_write = 1, mem_to_reg = 1, reg_dst = 0, then -> FETCH.
//   - MEMWR(5): mem_write = 1, iord = 1. Waits on mem_ready, then -> FETCH.
//   - EXEC(6): src_a = 1, src_b = 00, alu_op = 10, then -> ALUWB.
//   - ALUWB(7): reg_write = 1, reg_dst = 1, mem_to_reg = 0, then -> FETCH.
//   - BRANCH(8): src_a = 1, src_b = 00, alu_op = 01, pc_write_cond = 1,
//     pc_source = 01, then -> FETCH.
//   - JUMP(9): pc_write = 1, pc_source = 10, then -> FETCH.
//   - Encodings 10-15 are unreachable; if entered, go to FETCH.
//   - Latency with zero wait states (mem_ready held 1): R = 4 cycles, lw = 5,
//     sw = 4, beq = 3, j = 3. Each wait cycle adds exactly one cycle.
//   - Never assert mem_read and mem_write in the same cycle.
//   - At most one PC-load source is active per cycle.
// CONFIGURATION
//   MC_PERF_CNT_EN defined:
//     - Adds output retired[31:0]: +1 on every transition into FETCH from
//       MEMWB, MEMWR, ALUWB, BRANCH or JUMP.
//     - Adds output stall[31:0]: +1 on every cycle with mem_read or
//       mem_write = 1 and mem_ready = 0.
//     - Both counters clear to 0 on reset and wrap modulo 2^32.
//   MC_PERF_CNT_EN undefined: neither port exists; no counter logic.
// STRUCTURE
//   - mc_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J),
//     state localparams S_FETCH..S_JUMP, and pc_source/alu_src_b codes.
//   - Sub-module mc_perf_cnt (the two counters), instantiated only under
//     MC_PERF_CNT_EN.
// TESTING
//   - Reset: hold rst_n = 0 for 2 cycles -> state_o = 0, all outputs 0; with
//     rst_n = 1, mem_read = 1 on the first cycle.
//   - R-type, opcode 00, mem_ready = 1: states 0,1,6,7; reg_write = 1 and
//     reg_dst = 1 in cycle 4.
//   - lw, opcode 23, mem_ready = 0 for 3 cycles in MEMRD: state held at 3;
//     total 8 cycles; reg_write = 1 and mem_to_reg = 1 only in MEMWB.
//   - beq, opcode 04: zero = 1 -> pc_write_cond = 1 and pc_source = 01 in
//     cycle 3; zero = 0 -> same outputs, PC unit holds.
//   - Opcode 3F -> illegal_op pulses for 1 cycle in DECODE, next state 0,
//     reg_write/mem_write never asserted. Then a j (opcode 02) completes in
//     3 cycles with pc_source = 10.
//   - MC_PERF_CNT_EN: run R, lw, sw, beq, j with 2 stall cycles ->
//     retired = 5, stall = 2. Reset mid-lw -> both counters 0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle control FSM: opcodes, state encoding,
// mux select codes and the per-state control decode.
package mc_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned STATE_W  = 4;

  // Supported opcodes, instr[31:26]
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;

  // FSM states; encodings 10-15 are unused and recover to S_FETCH
  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_e;

  // pc_source codes
  localparam logic [1:0] PCS_INCR   = 2'b00;
  localparam logic [1:0] PCS_BRANCH = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  // alu_src_b codes
  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_SEXT  = 2'b10;
  localparam logic [1:0] SRCB_SHIFT = 2'b11;

  // alu_op codes
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // Moore control word. fetch_load marks FETCH, where ir_write and the PC
  // increment are qualified by mem_ready outside the register.
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       fetch_load;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  // Control word asserted while the FSM sits in a given state
  function automatic ctrl_t state_ctrl(input state_e st);
    ctrl_t c;
    c = '0;
    case (st)
      S_FETCH: begin
        c.mem_read   = 1'b1;
        c.fetch_load = 1'b1;
        c.alu_src_b  = SRCB_ONE;
        c.alu_op     = ALU_ADD;
        c.pc_source  = PCS_INCR;
      end
      S_DECODE: begin
        // Branch target precomputed while the register file is read
        c.alu_src_b = SRCB_SHIFT;
        c.alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_SEXT;
        c.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_RT;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCS_BRANCH;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCS_JUMP;
      end
      default: ;
    endcase
    return c;
  endfunction

  // True for the opcodes the FSM knows how to sequence
  function automatic logic op_legal(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_perf_cnt.sv
// Retired-instruction and memory-stall counters for mc_control.
// Only instantiated when MC_PERF_CNT_EN is defined.
module mc_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        retire_i,
  input  logic        stall_i,
  output logic [31:0] retired_o,
  output logic [31:0] stall_o
);

  logic [31:0] retired_q, stall_q;

  // Free-running counters, wrap modulo 2^32, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (retire_i) retired_q <= retired_q + 32'd1;
      if (stall_i)  stall_q   <= stall_q + 32'd1;
    end
  end

  assign retired_o = retired_q;
  assign stall_o   = stall_q;

endmodule

// File: rtl/mc_control.sv
// Main control FSM of the multi-cycle datapath: sequences PC, IR, register
// file, ALU and the shared instruction/data memory port (stalls on mem_ready).
// Optional build macro: MC_PERF_CNT_EN adds retired/stall performance counters.
module mc_control
  import mc_pkg::*;
#(
  parameter int unsigned OPW = 6,
  parameter int unsigned STW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           mem_read,
  output logic           mem_write,
  output logic           iord,
  output logic           ir_write,
  output logic           pc_write,
  output logic           pc_write_cond,
  output logic [1:0]     pc_source,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic           reg_dst,
  output logic           mem_to_reg,
  output logic           reg_write,
  output logic           illegal_op,
`ifdef MC_PERF_CNT_EN
  output logic [31:0]    retired,
  output logic [31:0]    stall,
`endif
  output logic [STW-1:0] state_o
);

  state_e                state_q, state_d;
  ctrl_t                 ctrl_q;
  logic [OPCODE_W-1:0]   op;

  assign op = OPCODE_W'(opcode);

  // zero is combined with pc_write_cond in the PC unit, not in this FSM
  logic unused_zero;
  assign unused_zero = zero;

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // State register plus the control word registered for the state being entered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ctrl_q  <= state_ctrl(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= state_ctrl(state_d);
    end
  end

  // Output drive: everything forced low while reset is asserted so an aborted
  // instruction can never leak a register or memory write.
  always_comb begin
    mem_read      = rst_n & ctrl_q.mem_read;
    mem_write     = rst_n & ctrl_q.mem_write;
    iord          = rst_n & ctrl_q.iord;
    ir_write      = rst_n & ctrl_q.fetch_load & mem_ready;
    pc_write      = rst_n & (ctrl_q.pc_write | (ctrl_q.fetch_load & mem_ready));
    pc_write_cond = rst_n & ctrl_q.pc_write_cond;
    pc_source     = rst_n ? ctrl_q.pc_source : 2'b00;
    alu_src_a     = rst_n & ctrl_q.alu_src_a;
    alu_src_b     = rst_n ? ctrl_q.alu_src_b : 2'b00;
    alu_op        = rst_n ? ctrl_q.alu_op : 2'b00;
    reg_dst       = rst_n & ctrl_q.reg_dst;
    mem_to_reg    = rst_n & ctrl_q.mem_to_reg;
    reg_write     = rst_n & ctrl_q.reg_write;
    // Opcode only becomes valid in DECODE, so this flag cannot be registered
    illegal_op    = rst_n & (state_q == S_DECODE) & ~op_legal(op);
    state_o       = rst_n ? STW'(state_q) : '0;
  end

`ifdef MC_PERF_CNT_EN
  logic retire_ev, stall_ev;

  // Completion = leaving a final state for FETCH; illegal opcodes never retire
  always_comb begin
    retire_ev = 1'b0;
    if (rst_n && state_d == S_FETCH) begin
      case (state_q)
        S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_JUMP: retire_ev = 1'b1;
        default:                                     retire_ev = 1'b0;
      endcase
    end
    stall_ev = (mem_read | mem_write) & ~mem_ready;
  end

  mc_perf_cnt u_perf_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .retire_i  (retire_ev),
    .stall_i   (stall_ev),
    .retired_o (retired),
    .stall_o   (stall)
  );
`endif

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed cycle table, then randomized
// instruction streams against a phase-queue reference model.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic       alu_src_a, reg_dst, mem_to_reg, reg_write, illegal_op;
  logic [3:0] state_o;
`ifdef MC_PERF_CNT_EN
  logic [31:0] retired, stall;
`endif

  always #5 clk = ~clk;

  mc_control dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .iord          (iord),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .illegal_op    (illegal_op),
`ifdef MC_PERF_CNT_EN
    .retired       (retired),
    .stall         (stall),
`endif
    .state_o       (state_o)
  );

  // Observed outputs, packed in a fixed order
  typedef struct packed {
    logic [3:0] st;
    logic mr, mw, iord, irw, pcw, pcwc;
    logic [1:0] pcs;
    logic asa;
    logic [1:0] asb, aop;
    logic rd, m2r, rw, ill;
  } obs_t;

  obs_t act;
  assign act = {state_o, mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
                pc_source, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
                illegal_op};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] a,
                     input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %h, want %h", name, idx, a, e);
    end
  endtask

  // Expected outputs for a cycle in state st, straight from the state table
  function automatic obs_t spec_out(input int st, input bit rdy, input bit rst, input bit ill);
    obs_t o;
    o = '0;
    if (!rst) return o;
    o.st  = 4'(st);
    o.ill = ill;
    case (st)
      0: begin o.mr = 1; o.asb = 2'b01; o.irw = rdy; o.pcw = rdy; end
      1: o.asb = 2'b11;
      2: begin o.asa = 1; o.asb = 2'b10; end
      3: begin o.mr = 1; o.iord = 1; end
      4: begin o.rw = 1; o.m2r = 1; end
      5: begin o.mw = 1; o.iord = 1; end
      6: begin o.asa = 1; o.aop = 2'b10; end
      7: begin o.rw = 1; o.rd = 1; end
      8: begin o.asa = 1; o.aop = 2'b01; o.pcwc = 1; o.pcs = 2'b01; end
      9: begin o.pcw = 1; o.pcs = 2'b10; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h02;
  endfunction

  // ---------------- directed cycle table ----------------
  typedef struct {
    bit         rst;
    logic [5:0] op;
    bit         zr;
    bit         rdy;
    int         st;
    bit         ill;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input bit rst, input logic [5:0] op, input bit zr, input bit rdy,
                      input int st, input bit ill);
    vec_t v;
    v.rst = rst; v.op = op; v.zr = zr; v.rdy = rdy; v.st = st; v.ill = ill;
    tbl.push_back(v);
  endtask

  // ---------------- reference model for random runs ----------------
  int         ph[$];     // remaining states of the current instruction
  logic [5:0] prog[$];   // forced opcode sequence, random when empty
  logic [5:0] cur_op = '0;
  int         m_ret = 0;
  int         m_stall = 0;
  int         stall_budget = 0;
  bit         rnd_rdy = 1'b0;

  function automatic logic [5:0] rand_op();
    case ($urandom_range(0, 6))
      0: return 6'h00;
      1: return 6'h23;
      2: return 6'h2B;
      3: return 6'h04;
      4: return 6'h02;
      5: return 6'h3F;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  // One clock cycle: drive, check before the edge, advance the model after it
  task automatic tick(input bit rst);
    int st;
    bit rdy, ill, memph;
    st = 0;
    if (rst) begin
      if (ph.size() == 0) begin
        cur_op = (prog.size() != 0) ? prog.pop_front() : rand_op();
        case (cur_op)
          6'h00:   ph = '{0, 1, 6, 7};
          6'h23:   ph = '{0, 1, 2, 3, 4};
          6'h2B:   ph = '{0, 1, 2, 5};
          6'h04:   ph = '{0, 1, 8};
          6'h02:   ph = '{0, 1, 9};
          default: ph = '{0, 1};
        endcase
      end
      st = ph[0];
    end
    memph = rst && (st == 0 || st == 3 || st == 5);
    rdy = 1'b1;
    if (rst && stall_budget > 0 && st == 3) begin
      rdy = 1'b0;
      stall_budget--;
    end else if (rnd_rdy) begin
      rdy = ($urandom_range(0, 3) != 0);
    end
    ill = rst && st == 1 && !legal(cur_op);
    rst_n = rst; opcode = cur_op; zero = 1'($urandom_range(0, 1)); mem_ready = rdy;
    @(negedge clk);
    chk("cycle", st, 32'(act), 32'(spec_out(st, rdy, rst, ill)));
    chk("rd_wr_exclusive", st, 32'(mem_read & mem_write), 32'd0);
    chk("pc_load_single", st, 32'(pc_write & pc_write_cond), 32'd0);
    @(posedge clk); #1;
    if (!rst) begin
      ph.delete(); m_ret = 0; m_stall = 0;
    end else if (memph && !rdy) begin
      m_stall++;
    end else begin
      ph.delete(0);
      if (ph.size() == 0 && legal(cur_op)) m_ret++;
    end
  endtask

  initial begin
    // reset (2 cycles)
    addv(0, 6'h00, 0, 1, 0, 0); addv(0, 6'h00, 0, 1, 0, 0);
    // R-type
    addv(1, 6'h00, 0, 1, 0, 0); addv(1, 6'h00, 0, 1, 1, 0);
    addv(1, 6'h00, 0, 1, 6, 0); addv(1, 6'h00, 0, 1, 7, 0);
    // beq taken / not taken: identical controls
    addv(1, 6'h04, 1, 1, 0, 0); addv(1, 6'h04, 1, 1, 1, 0); addv(1, 6'h04, 1, 1, 8, 0);
    addv(1, 6'h04, 0, 1, 0, 0); addv(1, 6'h04, 0, 1, 1, 0); addv(1, 6'h04, 0, 1, 8, 0);
    // illegal opcode then j
    addv(1, 6'h3F, 0, 1, 0, 0); addv(1, 6'h3F, 0, 1, 1, 1);
    addv(1, 6'h02, 0, 1, 0, 0); addv(1, 6'h02, 0, 1, 1, 0); addv(1, 6'h02, 0, 1, 9, 0);
    // lw with 3 wait cycles in MEMRD: 8 cycles
    addv(1, 6'h23, 0, 1, 0, 0); addv(1, 6'h23, 0, 1, 1, 0); addv(1, 6'h23, 0, 1, 2, 0);
    addv(1, 6'h23, 0, 0, 3, 0); addv(1, 6'h23, 0, 0, 3, 0); addv(1, 6'h23, 0, 0, 3, 0);
    addv(1, 6'h23, 0, 1, 3, 0); addv(1, 6'h23, 0, 1, 4, 0);
    // sw with one fetch wait and one write wait
    addv(1, 6'h2B, 0, 0, 0, 0); addv(1, 6'h2B, 0, 1, 0, 0); addv(1, 6'h2B, 0, 1, 1, 0);
    addv(1, 6'h2B, 0, 1, 2, 0); addv(1, 6'h2B, 0, 0, 5, 0); addv(1, 6'h2B, 0, 1, 5, 0);
    // reset mid-lw aborts it
    addv(1, 6'h23, 0, 1, 0, 0); addv(1, 6'h23, 0, 1, 1, 0); addv(1, 6'h23, 0, 1, 2, 0);
    addv(1, 6'h23, 0, 0, 3, 0); addv(0, 6'h23, 0, 1, 3, 0);
    addv(1, 6'h23, 0, 1, 0, 0); addv(1, 6'h23, 0, 1, 1, 0);

    @(posedge clk); #1;
    foreach (tbl[i]) begin
      rst_n = tbl[i].rst; opcode = tbl[i].op; zero = tbl[i].zr; mem_ready = tbl[i].rdy;
      @(negedge clk);
      chk("vec", i, 32'(act), 32'(spec_out(tbl[i].st, tbl[i].rdy, tbl[i].rst, tbl[i].ill)));
      @(posedge clk); #1;
    end

    // randomized instruction stream with random memory wait states
    tick(0); tick(0);
    rnd_rdy = 1'b1;
    repeat (1500) tick(1);
`ifdef MC_PERF_CNT_EN
    @(negedge clk);
    chk("retired_rand", 0, retired, 32'(m_ret));
    chk("stall_rand", 0, stall, 32'(m_stall));
    @(posedge clk); #1;

    // R, lw, sw, beq, j with 2 stall cycles
    tick(0); tick(0);
    rnd_rdy = 1'b0;
    prog = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02};
    stall_budget = 2;
    begin
      int guard;
      guard = 0;
      while ((prog.size() != 0 || ph.size() != 0) && guard < 100) begin
        tick(1);
        guard++;
      end
      chk("perf_seq_bound", guard, 32'(guard < 100), 32'd1);
    end
    chk("retired_5", 0, retired, 32'd5);
    chk("stall_2", 0, stall, 32'd2);
    chk("retired_model", 0, retired, 32'(m_ret));

    // reset mid-lw clears both counters
    prog = '{6'h23};
    stall_budget = 1;
    tick(1); tick(1); tick(1); tick(1);
    tick(0);
    chk("retired_after_rst", 0, retired, 32'd0);
    chk("stall_after_rst", 0, stall, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
